// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs load) for the register file write port plus busy scoreboard.
// Grant is same-cycle; write port is driven from flops one cycle later; losers hold valid until granted.
module regfile_wb_arbiter #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_reg,
  input  logic [DW-1:0]     alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [AW-1:0]     mem_reg,
  input  logic [DW-1:0]     mem_data,
  output logic              mem_ready,
  input  logic              iss_valid,
  input  logic              iss_dst_en,
  input  logic [AW-1:0]     iss_dst,
  input  logic [AW-1:0]     iss_src1,
  input  logic [AW-1:0]     iss_src2,
  output logic              iss_stall,
  output logic [2**AW-1:0]  busy,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata
);
  localparam int NR = 2**AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wb_t;

  logic          last_q, last_d;
  logic [NR-1:0] busy_q, busy_d;
  logic          rf_we_q, rf_we_d;
  wb_t           wb_q, wb_d;
  wb_t           wb_sel;
  logic          xfer, iss_acc;

  // last_q: 0 = ALU granted most recently, 1 = MEM; the other side wins a tie.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!reset) begin
      if (alu_valid && (!mem_valid || last_q)) alu_ready = 1'b1;
      else if (mem_valid)                      mem_ready = 1'b1;
    end
  end

  assign xfer      = alu_ready | mem_ready;
  assign wb_sel    = alu_ready ? wb_t'{addr: alu_reg, dat: alu_data}
                               : wb_t'{addr: mem_reg, dat: mem_data};
  assign iss_stall = iss_valid & (busy_q[iss_src1] | busy_q[iss_src2] |
                                  (iss_dst_en & busy_q[iss_dst]));
  assign iss_acc   = iss_valid & ~iss_stall & ~reset;

  always_comb begin
    last_d  = last_q;
    busy_d  = busy_q;
    rf_we_d = xfer;
    wb_d    = wb_q;
    if (xfer) begin
      last_d              = mem_ready;
      wb_d                = wb_sel;
      busy_d[wb_sel.addr] = 1'b0;
    end
    // Set after clear so a same-cycle set on the same register wins.
    if (iss_acc && iss_dst_en) busy_d[iss_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= 1'b1;
      busy_q  <= '0;
      rf_we_q <= 1'b0;
      wb_q    <= '0;
    end else begin
      last_q  <= last_d;
      busy_q  <= busy_d;
      rf_we_q <= rf_we_d;
      wb_q    <= wb_d;
    end
  end

  assign busy     = busy_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = wb_q.addr;
  assign rf_wdata = wb_q.dat;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, write-port timing, scoreboard and reset.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, alu_ready, mem_ready;
  logic [3:0]  alu_reg, mem_reg;
  logic [15:0] alu_data, mem_data;
  logic        iss_valid, iss_dst_en, iss_stall;
  logic [3:0]  iss_dst, iss_src1, iss_src2;
  logic [15:0] busy;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.DW(16), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .iss_valid(iss_valid), .iss_dst_en(iss_dst_en), .iss_dst(iss_dst),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_stall(iss_stall),
    .busy(busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one posedge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    mem_valid = 0; mem_reg = 0; mem_data = 0;
    iss_valid = 0; iss_dst_en = 0; iss_dst = 0; iss_src1 = 0; iss_src2 = 0;
    tick();
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_busy", busy, 16'h0000);
      chk("idle_we", rf_we, 0);
      chk("idle_alu_rdy", alu_ready, 0);
      chk("idle_mem_rdy", mem_ready, 0);
      tick();
    end

    // ALU only, reg 3
    alu_valid = 1; alu_reg = 4'd3; alu_data = 16'h1234;
    #1;
    chk("alu_only_rdy", alu_ready, 1);
    chk("alu_only_mem_rdy", mem_ready, 0);
    tick();
    alu_valid = 0;
    chk("alu_only_we", rf_we, 1);
    chk("alu_only_waddr", rf_waddr, 3);
    chk("alu_only_wdata", rf_wdata, 16'h1234);
    tick();
    chk("alu_only_we_off", rf_we, 0);
    chk("alu_only_hold_addr", rf_waddr, 3);

    // Both valid from reset: ALU first, then strict alternation
    reset = 1;
    alu_valid = 1; alu_reg = 4'd1; alu_data = 16'hAAAA;
    mem_valid = 1; mem_reg = 4'd2; mem_data = 16'h5555;
    #1;
    chk("rst_alu_rdy", alu_ready, 0);
    chk("rst_mem_rdy", mem_ready, 0);
    tick();
    reset = 0;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("rr_alu_rdy", alu_ready, (g % 2 == 0) ? 1 : 0);
      chk("rr_mem_rdy", mem_ready, (g % 2 == 0) ? 0 : 1);
      tick();
      chk("rr_we", rf_we, 1);
      chk("rr_waddr", rf_waddr, (g % 2 == 0) ? 1 : 2);
      chk("rr_wdata", rf_wdata, (g % 2 == 0) ? 16'hAAAA : 16'h5555);
    end
    alu_valid = 0; mem_valid = 0;
    tick();

    // Issue dst 5, then dependent src1 = 5 stalls until MEM write-back
    iss_valid = 1; iss_dst_en = 1; iss_dst = 4'd5; iss_src1 = 0; iss_src2 = 0;
    #1;
    chk("iss5_stall", iss_stall, 0);
    tick();
    chk("iss5_busy", busy, 16'h0020);
    iss_dst_en = 0; iss_dst = 0; iss_src1 = 4'd5;
    #1;
    chk("dep_stall0", iss_stall, 1);
    tick();
    chk("dep_stall1", iss_stall, 1);
    mem_valid = 1; mem_reg = 4'd5; mem_data = 16'hBEEF;
    #1;
    chk("wb5_mem_rdy", mem_ready, 1);
    chk("wb5_stall_grant_cyc", iss_stall, 1);
    tick();
    mem_valid = 0;
    #1;
    chk("wb5_stall_after", iss_stall, 0);
    chk("wb5_busy", busy, 16'h0000);
    chk("wb5_waddr", rf_waddr, 5);
    chk("wb5_wdata", rf_wdata, 16'hBEEF);
    tick();
    chk("dep_no_mark", busy, 16'h0000);

    // Busy destination stalls; no-dst issue passes
    iss_dst_en = 1; iss_dst = 4'd7; iss_src1 = 0; iss_src2 = 0;
    tick();
    chk("iss7_busy", busy, 16'h0080);
    #1;
    chk("iss7_dst_stall", iss_stall, 1);
    tick();
    chk("iss7_busy_same", busy, 16'h0080);
    iss_dst_en = 0;
    #1;
    chk("iss7_nodst_stall", iss_stall, 0);
    tick();
    chk("iss7_nodst_busy", busy, 16'h0080);

    // Fill busy = 0x00FF, then reset during an ALU request
    iss_dst_en = 1;
    for (int r = 0; r < 7; r++) begin
      iss_dst = 4'(r); iss_src1 = 4'(r); iss_src2 = 4'(r);
      tick();
    end
    iss_valid = 0; iss_dst_en = 0;
    chk("fill_busy", busy, 16'h00FF);
    alu_valid = 1; alu_reg = 4'd3; alu_data = 16'hDEAD;
    reset = 1;
    #1;
    chk("rst_drop_rdy", alu_ready, 0);
    tick();
    chk("rst_drop_busy", busy, 16'h0000);
    chk("rst_drop_we", rf_we, 0);
    chk("rst_drop_wdata", rf_wdata, 16'h0000);
    reset = 0; alu_valid = 0;
    tick();
    chk("rst_drop_we2", rf_we, 0);
    chk("rst_drop_wdata2", rf_wdata, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
